// File: rtl/lsh_pkg.sv
// Shared types for the LSH front end: nucleotide encoding, decoder payload,
// window stride derivation and the window_assembler FSM state enum.
package lsh_pkg;

    localparam int unsigned WINDOW_SIZE_DEF   = 128;
    localparam int unsigned KMER_SIZE_DEF     = 16;
    localparam int unsigned MAX_WIN_REF_DEF   = 512;
    localparam int unsigned MAX_WIN_READ_DEF  = 16;

    typedef logic [1:0] nucleotide_t;

    localparam nucleotide_t NUC_A = 2'b00;
    localparam nucleotide_t NUC_C = 2'b01;
    localparam nucleotide_t NUC_G = 2'b10;
    localparam nucleotide_t NUC_T = 2'b11;

    // Decoder result: valid=0 means the character is consumed but not stored
    typedef struct packed {
        logic        valid;
        nucleotide_t nuc;
    } nuc_dec_t;

    typedef enum logic [2:0] {
        WA_FILL   = 3'd0,
        WA_HRST   = 3'd1,
        WA_HASH   = 3'd2,
        WA_COMMIT = 3'd3,
        WA_DONE   = 3'd4
    } wa_state_e;

    // New characters needed between consecutive overlapping windows
    function automatic int unsigned wa_stride(input int unsigned window_size,
                                              input int unsigned kmer_size);
        return window_size - kmer_size + 1;
    endfunction

endpackage

// File: rtl/window_assembler_if.sv
// Stream, window and hasher-handshake signals of window_assembler.
// master = sequence source / hasher side, slave = the assembler.
interface window_assembler_if #(
    parameter int unsigned WINDOW_SIZE = lsh_pkg::WINDOW_SIZE_DEF
);
    logic                 nuc_valid;
    logic [7:0]           nuc_data;
    logic                 nuc_last;
    logic                 nuc_ready;
    logic                 is_reference;
    lsh_pkg::nucleotide_t window [0:WINDOW_SIZE-1];
    logic [31:0]          window_id;
    logic                 reset_window_hasher;
    logic                 ready_for_hashing;
    logic                 hashing_is_done;
    logic                 is_insert;
    logic                 is_query;
    logic                 stream_done;
    logic                 window_overflow;

    modport master (
        output nuc_valid, nuc_data, nuc_last, is_reference, hashing_is_done,
        input  nuc_ready, window, window_id, reset_window_hasher, ready_for_hashing,
               is_insert, is_query, stream_done, window_overflow
    );

    modport slave (
        input  nuc_valid, nuc_data, nuc_last, is_reference, hashing_is_done,
        output nuc_ready, window, window_id, reset_window_hasher, ready_for_hashing,
               is_insert, is_query, stream_done, window_overflow
    );
endinterface

// File: rtl/nuc_decoder.sv
// Combinational ASCII to 2-bit nucleotide decoder.
// WINDOW_ASSEMBLER_LOWERCASE_EN: also accept a/c/g/t.
module nuc_decoder
    import lsh_pkg::*;
(
    input  logic [7:0] i_ascii,
    output nuc_dec_t   o_dec_c
);

    always_comb begin
        o_dec_c.valid = 1'b0;
        o_dec_c.nuc   = NUC_A;
        case (i_ascii)
            8'h41: begin o_dec_c.valid = 1'b1; o_dec_c.nuc = NUC_A; end
            8'h43: begin o_dec_c.valid = 1'b1; o_dec_c.nuc = NUC_C; end
            8'h47: begin o_dec_c.valid = 1'b1; o_dec_c.nuc = NUC_G; end
            8'h54: begin o_dec_c.valid = 1'b1; o_dec_c.nuc = NUC_T; end
`ifdef WINDOW_ASSEMBLER_LOWERCASE_EN
            8'h61: begin o_dec_c.valid = 1'b1; o_dec_c.nuc = NUC_A; end
            8'h63: begin o_dec_c.valid = 1'b1; o_dec_c.nuc = NUC_C; end
            8'h67: begin o_dec_c.valid = 1'b1; o_dec_c.nuc = NUC_G; end
            8'h74: begin o_dec_c.valid = 1'b1; o_dec_c.nuc = NUC_T; end
`else
            8'h61, 8'h63, 8'h67, 8'h74: o_dec_c.valid = 1'b0;
`endif
            default: o_dec_c.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/window_assembler.sv
// Packs a streamed nucleotide sequence into overlapping 2-bit windows and runs the
// window_hasher / hash_table handshake. Lowercase support: WINDOW_ASSEMBLER_LOWERCASE_EN.
module window_assembler
    import lsh_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE              = WINDOW_SIZE_DEF,
    parameter int unsigned KMER_SIZE                = KMER_SIZE_DEF,
    parameter int unsigned MAX_WINDOWS_IN_REFERENCE = MAX_WIN_REF_DEF,
    parameter int unsigned MAX_WINDOWS_IN_READ      = MAX_WIN_READ_DEF
) (
    input logic               clk,
    input logic               reset_window_assembler_n,
    window_assembler_if.slave bus
);

    localparam int unsigned FILL_W = $clog2(WINDOW_SIZE + 1);
    localparam int unsigned REFILL = WINDOW_SIZE - wa_stride(WINDOW_SIZE, KMER_SIZE);

    wa_state_e          r_state;
    wa_state_e          w_state_nxt;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_after;
    logic [31:0]        r_window_id;
    logic [31:0]        w_cap;
    nucleotide_t        r_window [0:WINDOW_SIZE-1];

    logic r_nuc_ready;
    logic r_reset_window_hasher;
    logic r_ready_for_hashing;
    logic r_is_insert;
    logic r_is_query;
    logic r_stream_done;
    logic r_window_overflow;

    logic r_first;
    logic r_is_ref;
    logic r_last_seen;
    logic r_drain;

    nuc_dec_t w_dec;
    logic     w_accept;
    logic     w_write;
    logic     w_cap_hit;
    logic     w_nuc_ready_nxt;
    logic     w_rwh_nxt;
    logic     w_rfh_nxt;
    logic     w_insert_nxt;
    logic     w_query_nxt;
    logic     w_done_nxt;

    nuc_decoder u_nuc_decoder (
        .i_ascii (bus.nuc_data),
        .o_dec_c (w_dec)
    );

    // Accept/write qualification; drained streams consume characters without storing them
    always_comb begin
        w_accept     = bus.nuc_valid && r_nuc_ready;
        w_write      = w_accept && w_dec.valid && !r_drain;
        w_fill_after = w_write ? r_fill + FILL_W'(1) : r_fill;
        w_cap        = r_is_ref ? 32'(MAX_WINDOWS_IN_REFERENCE) : 32'(MAX_WINDOWS_IN_READ);
        w_cap_hit    = (r_window_id == w_cap);
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_nuc_ready_nxt = 1'b0;
        w_rwh_nxt       = 1'b0;
        w_rfh_nxt       = 1'b0;
        w_insert_nxt    = 1'b0;
        w_query_nxt     = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            WA_FILL: begin
                if (w_accept) begin
                    if (w_fill_after == FILL_W'(WINDOW_SIZE)) begin
                        w_state_nxt = WA_HRST;
                    end else if (bus.nuc_last) begin
                        w_state_nxt = WA_DONE;
                    end
                end
            end
            WA_HRST:   w_state_nxt = WA_HASH;
            WA_HASH: begin
                if (bus.hashing_is_done) begin
                    w_state_nxt = WA_COMMIT;
                end
            end
            WA_COMMIT: w_state_nxt = r_last_seen ? WA_DONE : WA_FILL;
            WA_DONE:   w_state_nxt = WA_FILL;
            default:   w_state_nxt = WA_FILL;
        endcase

        w_nuc_ready_nxt = (w_state_nxt == WA_FILL);
        w_rwh_nxt       = (w_state_nxt == WA_HRST);
        w_rfh_nxt       = (w_state_nxt == WA_HASH);
        w_done_nxt      = (w_state_nxt == WA_DONE);
        if ((r_state == WA_HASH) && (w_state_nxt == WA_COMMIT) && !w_cap_hit) begin
            w_insert_nxt = r_is_ref;
            w_query_nxt  = !r_is_ref;
        end
    end

    always_ff @(posedge clk or negedge reset_window_assembler_n) begin
        if (!reset_window_assembler_n) begin
            r_state <= WA_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_window_assembler_n) begin
        if (!reset_window_assembler_n) begin
            r_nuc_ready           <= 1'b0;
            r_reset_window_hasher <= 1'b0;
            r_ready_for_hashing   <= 1'b0;
            r_is_insert           <= 1'b0;
            r_is_query            <= 1'b0;
            r_stream_done         <= 1'b0;
        end else begin
            r_nuc_ready           <= w_nuc_ready_nxt;
            r_reset_window_hasher <= w_rwh_nxt;
            r_ready_for_hashing   <= w_rfh_nxt;
            r_is_insert           <= w_insert_nxt;
            r_is_query            <= w_query_nxt;
            r_stream_done         <= w_done_nxt;
        end
    end

    // Stream bookkeeping: fill level, window index, stream type, cap/drain and end-of-stream flags
    always_ff @(posedge clk or negedge reset_window_assembler_n) begin
        if (!reset_window_assembler_n) begin
            r_fill            <= '0;
            r_window_id       <= '0;
            r_first           <= 1'b1;
            r_is_ref          <= 1'b0;
            r_last_seen       <= 1'b0;
            r_drain           <= 1'b0;
            r_window_overflow <= 1'b0;
        end else begin
            if (w_accept && r_first) begin
                r_first           <= 1'b0;
                r_is_ref          <= bus.is_reference;
                r_window_overflow <= 1'b0;
            end
            if (w_accept && bus.nuc_last) begin
                r_last_seen <= 1'b1;
            end
            if ((r_state == WA_HASH) && (w_state_nxt == WA_COMMIT) && w_cap_hit) begin
                r_window_overflow <= 1'b1;
            end
            case (r_state)
                WA_FILL: r_fill <= w_fill_after;
                WA_COMMIT: begin
                    r_fill <= FILL_W'(REFILL);
                    if (w_cap_hit) begin
                        r_drain <= 1'b1;
                    end else begin
                        r_window_id <= r_window_id + 32'd1;
                    end
                end
                WA_DONE: begin
                    r_fill      <= '0;
                    r_window_id <= '0;
                    r_first     <= 1'b1;
                    r_last_seen <= 1'b0;
                    r_drain     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Window shift register: newest nucleotide at the top index, oldest at index 0
    always_ff @(posedge clk or negedge reset_window_assembler_n) begin
        if (!reset_window_assembler_n) begin
            for (int i = 0; i < int'(WINDOW_SIZE); i++) begin
                r_window[i] <= NUC_A;
            end
        end else if (w_write) begin
            for (int i = 0; i < int'(WINDOW_SIZE) - 1; i++) begin
                r_window[i] <= r_window[i+1];
            end
            r_window[WINDOW_SIZE-1] <= w_dec.nuc;
        end
    end

    assign bus.nuc_ready           = r_nuc_ready;
    assign bus.window              = r_window;
    assign bus.window_id           = r_window_id;
    assign bus.reset_window_hasher = r_reset_window_hasher;
    assign bus.ready_for_hashing   = r_ready_for_hashing;
    assign bus.is_insert           = r_is_insert;
    assign bus.is_query            = r_is_query;
    assign bus.stream_done         = r_stream_done;
    assign bus.window_overflow     = r_window_overflow;

endmodule

// File: tb/tb_window_assembler.sv
// Self-checking bench for window_assembler: table of streams with a reference-model
// scoreboard of committed windows, plus hand-written reset sequences.
module tb_window_assembler;
    import lsh_pkg::*;

    localparam int unsigned WS     = 128;
    localparam int unsigned KS     = 16;
    localparam int unsigned MAX_RF = 512;
    localparam int unsigned MAX_RD = 16;

    typedef struct {
        bit              ins;
        int unsigned     id;
        logic [2*WS-1:0] win;
    } exp_t;

    typedef struct {
        bit          is_ref;
        int          pattern;
        int unsigned len;
        int unsigned delay;
        int unsigned exp_commits;
        bit          exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    int          n_vec  = 0;
    int          n_err  = 0;
    int unsigned cyc    = 0;
    int unsigned n_commit = 0;
    int unsigned n_done = 0;
    int unsigned n_rwh  = 0;
    int unsigned done_cyc = 0;
    bit          prev_rwh = 1'b0;
    bit          hash_hold = 1'b0;
    int unsigned hash_delay = 1;

    exp_t        sb[$];
    byte unsigned stm[$];
    vec_t        tbl [8];

    window_assembler_if #(.WINDOW_SIZE(WS)) bus ();

    window_assembler #(
        .WINDOW_SIZE              (WS),
        .KMER_SIZE                (KS),
        .MAX_WINDOWS_IN_REFERENCE (MAX_RF),
        .MAX_WINDOWS_IN_READ      (MAX_RD)
    ) dut (
        .clk                      (clk),
        .reset_window_assembler_n (rst_n),
        .bus                      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_win(input string name, input logic [2*WS-1:0] act, input logic [2*WS-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_dec(input byte unsigned c, output logic [1:0] n);
        n = 2'b00;
        model_dec = 1'b1;
        case (c)
            8'h41: n = 2'b00;
            8'h43: n = 2'b01;
            8'h47: n = 2'b10;
            8'h54: n = 2'b11;
`ifdef WINDOW_ASSEMBLER_LOWERCASE_EN
            8'h61: n = 2'b00;
            8'h63: n = 2'b01;
            8'h67: n = 2'b10;
            8'h74: n = 2'b11;
`endif
            default: model_dec = 1'b0;
        endcase
    endfunction

    function automatic byte unsigned acgt(input int unsigned k);
        case (k % 4)
            0:       return 8'h41;
            1:       return 8'h43;
            2:       return 8'h47;
            default: return 8'h54;
        endcase
    endfunction

    // 0: all A, 1: ACGT repeat, 2: ACGT with 'N' after each of the first 10, 3: random, 4: ACGT with lowercase 'g'
    task automatic gen_stream(input int pattern, input int unsigned len);
        int unsigned k = 0;
        stm.delete();
        while (stm.size() < len) begin
            case (pattern)
                0: stm.push_back(8'h41);
                1: stm.push_back(acgt(k));
                2: begin
                    stm.push_back(acgt(k));
                    if (k < 10 && stm.size() < len) stm.push_back(8'h4E);
                end
                3: stm.push_back(acgt($urandom_range(0, 3)));
                default: stm.push_back((k % 33 == 32) ? 8'h67 : acgt(k));
            endcase
            k++;
        end
    endtask

    // Drives one stream; the model pushes each expected commit when its closing character is accepted
    task automatic send_stream(input bit is_ref, input int unsigned len,
                               output int unsigned hashed, output bit end_on_window,
                               output int unsigned last_edge);
        logic [2*WS-1:0] mw;
        logic [1:0]      nv;
        int unsigned     mfill, mid, i, wait_cnt;
        int unsigned     cap;
        bit              mdrain, first_pending;
        exp_t            e;
        mw = '0; mfill = 0; mid = 0; i = 0; wait_cnt = 0;
        mdrain = 1'b0; first_pending = 1'b0;
        hashed = 0; end_on_window = 1'b0; last_edge = 0;
        cap = is_ref ? MAX_RF : MAX_RD;
        while (i < len) begin
            @(negedge clk);
            if (first_pending) begin
                chk("overflow_clear_on_first_accept", bus.window_overflow, 0);
                first_pending = 1'b0;
            end
            bus.nuc_valid    = 1'b1;
            bus.nuc_data     = stm[i];
            bus.nuc_last     = (i == len - 1);
            bus.is_reference = (i == 0) ? is_ref : ~is_ref;
            if (bus.nuc_ready) begin
                wait_cnt  = 0;
                last_edge = cyc + 1;
                if (i == 0) first_pending = 1'b1;
                if (model_dec(stm[i], nv) && !mdrain) begin
                    mw = {nv, mw[2*WS-1:2]};
                    mfill++;
                    if (mfill == WS) begin
                        hashed++;
                        end_on_window = (i == len - 1);
                        if (mid == cap) begin
                            mdrain = 1'b1;
                        end else begin
                            e.ins = is_ref; e.id = mid; e.win = mw;
                            sb.push_back(e);
                            mid++;
                        end
                        mfill = KS - 1;
                    end
                end
                i++;
            end else begin
                wait_cnt++;
                if (wait_cnt > 300) begin
                    chk("nuc_ready_timeout", wait_cnt, 0);
                    i = len;
                end
            end
        end
        @(negedge clk);
        bus.nuc_valid = 1'b0;
        bus.nuc_last  = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        int unsigned hashed, last_edge, c0, d0, r0, wait_cnt;
        bit          end_on_window;
        gen_stream(v.pattern, v.len);
        hash_delay = v.delay;
        c0 = n_commit; d0 = n_done; r0 = n_rwh;
        send_stream(v.is_ref, v.len, hashed, end_on_window, last_edge);
        wait_cnt = 0;
        while (n_done == d0 && wait_cnt < 400) begin
            @(negedge clk);
            wait_cnt++;
        end
        repeat (3) @(negedge clk);
        chk("stream_done_count", n_done - d0, 1);
        chk("commit_count", n_commit - c0, v.exp_commits);
        chk("scoreboard_drained", sb.size(), 0);
        chk("hasher_reset_count", n_rwh - r0, hashed);
        chk("window_overflow", bus.window_overflow, v.exp_ovf);
        chk("window_id_after_done", bus.window_id, 0);
        chk("nuc_ready_idle", bus.nuc_ready, 1);
        if (!end_on_window) chk("done_latency", done_cyc, last_edge);
        sb.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        logic [2*WS-1:0] pw;
        for (int i = 0; i < int'(WS); i++) pw[2*i +: 2] = bus.window[i];
        chk({tag, "_nuc_ready"}, bus.nuc_ready, 0);
        chk({tag, "_reset_window_hasher"}, bus.reset_window_hasher, 0);
        chk({tag, "_ready_for_hashing"}, bus.ready_for_hashing, 0);
        chk({tag, "_is_insert"}, bus.is_insert, 0);
        chk({tag, "_is_query"}, bus.is_query, 0);
        chk({tag, "_stream_done"}, bus.stream_done, 0);
        chk({tag, "_window_overflow"}, bus.window_overflow, 0);
        chk({tag, "_window_id"}, bus.window_id, 0);
        chk_win({tag, "_window"}, pw, '0);
    endtask

    // Commit monitor / scoreboard consumer and handshake ordering checks
    always @(negedge clk) begin
        logic [2*WS-1:0] pw;
        exp_t            e;
        if (rst_n) begin
            if (bus.is_insert || bus.is_query) begin
                n_commit++;
                chk("commit_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    for (int i = 0; i < int'(WS); i++) pw[2*i +: 2] = bus.window[i];
                    chk("commit_is_insert", bus.is_insert, e.ins);
                    chk("commit_is_query", bus.is_query, !e.ins);
                    chk("commit_window_id", bus.window_id, e.id);
                    chk_win("commit_window", pw, e.win);
                end
            end
            if (bus.stream_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.reset_window_hasher) n_rwh++;
            if (prev_rwh) chk("ready_follows_hasher_reset",
                              {bus.ready_for_hashing, bus.reset_window_hasher}, 2'b10);
            prev_rwh = bus.reset_window_hasher;
        end else begin
            prev_rwh = 1'b0;
        end
    end

    // Hasher model: raises hashing_is_done after hash_delay cycles of ready_for_hashing
    initial begin
        int unsigned hcnt;
        hcnt = 0;
        bus.hashing_is_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.hashing_is_done = 1'b0;
            if (bus.ready_for_hashing && !hash_hold) begin
                hcnt++;
                if (hcnt >= hash_delay) begin
                    bus.hashing_is_done = 1'b1;
                    hcnt = 0;
                end
            end else begin
                hcnt = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0, wait_cnt, hashed, last_edge;
        bit          end_on_window;
        vec_t        rv;

        tbl[0] = '{1'b1, 0, 128,  3, 1,  1'b0};
        tbl[1] = '{1'b0, 1, 241,  2, 2,  1'b0};
        tbl[2] = '{1'b1, 3, 200,  1, 1,  1'b0};
        tbl[3] = '{1'b0, 2, 138,  1, 1,  1'b0};
        tbl[4] = '{1'b0, 1, 1956, 1, 16, 1'b1};
        tbl[5] = '{1'b1, 3, 354,  4, 3,  1'b0};
        tbl[6] = '{1'b0, 4, 132,  2, 1,  1'b0};
        tbl[7] = '{1'b0, 3, 127,  1, 0,  1'b0};

        bus.nuc_valid    = 1'b0;
        bus.nuc_data     = 8'h00;
        bus.nuc_last     = 1'b0;
        bus.is_reference = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("nuc_ready_before_first_edge", bus.nuc_ready, 0);
        @(negedge clk);
        chk("nuc_ready_after_first_edge", bus.nuc_ready, 1);

        for (int k = 0; k < 8; k++) run_vector(tbl[k]);

        // Reset while the assembler waits in HASH
        hash_hold = 1'b1;
        gen_stream(0, 128);
        send_stream(1'b1, 128, hashed, end_on_window, last_edge);
        wait_cnt = 0;
        while (!bus.ready_for_hashing && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("reached_hash_state", bus.ready_for_hashing, 1);
        repeat (2) @(negedge clk);
        c0 = n_commit;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) @(negedge clk);
        sb.delete();
        hash_hold = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("midreset_nuc_ready_before_edge", bus.nuc_ready, 0);
        repeat (3) @(negedge clk);
        chk("no_commit_after_midreset", n_commit - c0, 0);
        chk("midreset_nuc_ready_after_edge", bus.nuc_ready, 1);
        rv = '{1'b1, 3, 128, 2, 1, 1'b0};
        run_vector(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
